uart_pkt_rx: RTL

Packet deframer on the receive side of the wireless UART link. It consumes the byte stream from the uart receiver (data_out / data_ready) and hunts for framed packets of the form SYNC, LEN, LEN payload bytes, CHK. Each payload is buffered and checksum-verified before any byte leaves the block; verified payloads go to the logger datapath over a valid/ready stream. Bad, truncated or overrunning packets are dropped, and each is flagged on a one-cycle error pulse.

---
 rtl/uart_pkt_pkg.sv | 21 ++
 rtl/counter.sv | 30 +++
 rtl/pkt_buffer.sv | 29 ++
 rtl/uart_pkt_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared types and helpers for the packet deframer.
//   state_e           - deframer FSM states
//   SYNC_BYTE_DEFAULT - default frame start marker
//   chk_update        - running XOR checksum step
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        StHunt,
        StLen,
        StPayload,
        StCheck,
        StDrain
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/counter.sv
// counter: free-running up counter with synchronous clear.
//   clk, rst (async active-low) - clock / reset
//   clr                         - synchronous clear, has priority over en
//   en                          - count enable
//   count                       - current value
module counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pkt_buffer.sv
// pkt_buffer: DEPTH x WIDTH register file holding one packet payload.
//   clk                 - clock
//   we, waddr, wdata    - synchronous write port
//   raddr -> rdata      - asynchronous read port
// No reset: contents are only read after being written for the current packet.
module pkt_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: receive-side packet deframer (SYNC, LEN, payload, CHK).
//   clk, rst (async active-low)   - clock / reset
//   byte_valid, byte_in           - byte stream from the uart receiver
//   out_valid/out_ready/out_data  - verified payload stream
//   out_last, pkt_len             - last-byte marker, length of draining packet
//   crc_err, len_err, timeout_err, overrun - one-cycle registered error pulses
module uart_pkt_rx
    import uart_pkt_pkg::*;
#(
    parameter int unsigned     DATA      = 8,
    parameter int unsigned     MAX_LEN   = 16,
    parameter logic [DATA-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int unsigned     TIMEOUT   = 104160
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         byte_valid,
    input  logic [DATA-1:0]              byte_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA-1:0]              out_data,
    output logic                         out_last,
    output logic [$clog2(MAX_LEN+1)-1:0] pkt_len,
    output logic                         crc_err,
    output logic                         len_err,
    output logic                         timeout_err,
    output logic                         overrun
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    state_e          state_q, state_d;
    logic [LW-1:0]   pkt_len_q, pkt_len_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [7:0]      chk_q, chk_d;
    logic            crc_err_q, crc_err_d;
    logic            len_err_q, len_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            overrun_q, overrun_d;

    logic            buf_we;
    logic [DATA-1:0] buf_rdata;
    logic            cnt_clr;
    logic [TW-1:0]   idle_cnt;
    logic            idle_expired;

    pkt_buffer #(
        .DEPTH (MAX_LEN),
        .WIDTH (DATA),
        .AW    (IW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_idx_q),
        .wdata (byte_in),
        .raddr (rd_idx_q),
        .rdata (buf_rdata)
    );

    counter #(
        .WIDTH (TW)
    ) u_idle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (1'b1),
        .count (idle_cnt)
    );

    // A byte arriving in the threshold cycle takes priority over the timeout.
    assign idle_expired = (idle_cnt == TW'(TIMEOUT - 1)) && !byte_valid;

    assign out_valid = (state_q == StDrain);
    assign out_data  = out_valid ? buf_rdata : '0;
    assign out_last  = out_valid && (LW'(rd_idx_q) == pkt_len_q - LW'(1));
    assign pkt_len   = pkt_len_q;

    always_comb begin
        state_d       = state_q;
        pkt_len_d     = pkt_len_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        chk_d         = chk_q;
        crc_err_d     = 1'b0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        overrun_d     = 1'b0;
        buf_we        = 1'b0;
        // Counter only runs between bytes of a packet in progress.
        cnt_clr       = 1'b1;

        unique case (state_q)
            StHunt: begin
                if (byte_valid && byte_in == SYNC_BYTE) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                cnt_clr = byte_valid;
                if (byte_valid) begin
                    if (byte_in == '0 || 32'(byte_in) > MAX_LEN) begin
                        len_err_d = 1'b1;
                        state_d   = StHunt;
                    end else begin
                        pkt_len_d = LW'(byte_in);
                        chk_d     = byte_in;
                        wr_idx_d  = '0;
                        state_d   = StPayload;
                    end
                end else if (idle_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = StHunt;
                end
            end
            StPayload: begin
                cnt_clr = byte_valid;
                if (byte_valid) begin
                    buf_we   = 1'b1;
                    chk_d    = chk_update(chk_q, byte_in);
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (LW'(wr_idx_q) == pkt_len_q - LW'(1)) begin
                        state_d = StCheck;
                    end
                end else if (idle_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = StHunt;
                end
            end
            StCheck: begin
                cnt_clr = byte_valid;
                if (byte_valid) begin
                    if (byte_in == chk_q) begin
                        rd_idx_d = '0;
                        state_d  = StDrain;
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = StHunt;
                    end
                end else if (idle_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = StHunt;
                end
            end
            StDrain: begin
                overrun_d = byte_valid;
                if (out_ready) begin
                    if (out_last) begin
                        state_d = StHunt;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StHunt;
            pkt_len_q     <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            chk_q         <= '0;
            crc_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pkt_len_q     <= pkt_len_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            chk_q         <= chk_d;
            crc_err_q     <= crc_err_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign crc_err     = crc_err_q;
    assign len_err     = len_err_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule
